// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: count width and parameter legality.
package sync_fifo_pkg;

  // Occupancy runs 0..Depth inclusive, so one bit more than the address.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

  // Legal configurations: non-zero width, power-of-2 depth,
  // almost-full threshold in 1..Depth, almost-empty threshold in 0..Depth-1.
  function automatic bit params_ok(input int width, input int depth,
                                   input int af_thresh, input int ae_thresh);
    return (width >= 1) && is_pow2(depth) &&
           (af_thresh >= 1) && (af_thresh <= depth) &&
           (ae_thresh >= 0) && (ae_thresh <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: increments modulo 2**AddrWidth, synchronous clear.
module fifo_ptr #(
  parameter int AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [AddrWidth-1:0] ptr
);

  // Clear wins over increment so a flush always lands both pointers on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush, full+read pass-through
// and sticky overflow/underflow flags.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int Width             = 12,
  parameter int Depth             = 16,
  parameter int AlmostFullThresh  = Depth - 2,
  parameter int AlmostEmptyThresh = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        w,
  input  logic [Width-1:0]            wd,
  output logic                        wfull,
  output logic                        walmostfull,
  input  logic                        r,
  output logic [Width-1:0]            rd,
  output logic                        rempty,
  output logic                        ralmostempty,
  output logic [$clog2(Depth):0]      count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int AW = $clog2(Depth);
  localparam int CW = count_width(Depth);

  localparam logic [CW-1:0] DEPTH_C = CW'(Depth);
  localparam logic [CW-1:0] AF_C    = CW'(AlmostFullThresh);
  localparam logic [CW-1:0] AE_C    = CW'(AlmostEmptyThresh);

  if (!params_ok(Width, Depth, AlmostFullThresh, AlmostEmptyThresh)) begin : g_bad_params
    $error("sync_fifo: illegal parameters (Depth must be a power of 2 >= 2, thresholds in range)");
  end

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    waddr;
  logic [AW-1:0]    raddr;
  logic             wacc;
  logic             racc;

  // Accept decode; a flush cycle accepts nothing. At full, a simultaneous
  // read frees the head slot so the write is taken as well.
  always_comb begin
    wacc = w & (~wfull | r) & ~flush;
    racc = r & ~rempty & ~flush;
  end

  fifo_ptr #(.AddrWidth(AW)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (wacc),
    .ptr   (waddr)
  );

  fifo_ptr #(.AddrWidth(AW)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .inc   (racc),
    .ptr   (raddr)
  );

  // Storage array; deliberately unreset so it maps to distributed RAM.
  // On a full pass-through waddr == raddr, so the new word lands in the
  // slot the head is leaving and becomes the tail.
  always_ff @(posedge clk) begin
    if (wacc) begin
      mem[waddr] <= wd;
    end
  end

  // Show-ahead read straight from the array.
  always_comb begin
    rd = mem[raddr];
  end

  // Occupancy register; full/empty come from here, not from pointer compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (wacc && !racc) begin
      count <= count + 1'b1;
    end else if (racc && !wacc) begin
      count <= count - 1'b1;
    end
  end

  // Status flags decoded from the registered count.
  always_comb begin
    rempty       = (count == '0);
    wfull        = (count == DEPTH_C);
    walmostfull  = (count >= AF_C);
    ralmostempty = (count <= AE_C);
  end

  // Sticky error flags; only flush or reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w && wfull && !r) begin
        overflow <= 1'b1;
      end
      if (r && rempty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo (Width 12, Depth 4, AF 3, AE 1) against
// a queue-based reference model.
module tb_sync_fifo;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             w;
  logic [WIDTH-1:0] wd;
  logic             wfull;
  logic             walmostfull;
  logic             r;
  logic [WIDTH-1:0] rd;
  logic             rempty;
  logic             ralmostempty;
  logic [2:0]       count;
  logic             overflow;
  logic             underflow;

  sync_fifo #(
    .Width(WIDTH), .Depth(DEPTH), .AlmostFullThresh(AF), .AlmostEmptyThresh(AE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .w(w), .wd(wd),
    .wfull(wfull), .walmostfull(walmostfull), .r(r), .rd(rd),
    .rempty(rempty), .ralmostempty(ralmostempty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] model_q[$];
  bit               model_ov;
  bit               model_un;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = model_q.size();
    chk({tag, ".count"}, 32'(count), 32'(sz));
    chk({tag, ".rempty"}, 32'(rempty), 32'(sz == 0));
    chk({tag, ".wfull"}, 32'(wfull), 32'(sz == DEPTH));
    chk({tag, ".walmostfull"}, 32'(walmostfull), 32'(sz >= AF));
    chk({tag, ".ralmostempty"}, 32'(ralmostempty), 32'(sz <= AE));
    chk({tag, ".overflow"}, 32'(overflow), 32'(model_ov));
    chk({tag, ".underflow"}, 32'(underflow), 32'(model_un));
    if (sz > 0) chk({tag, ".rd"}, 32'(rd), 32'(model_q[0]));
  endtask

  // Reference behaviour: a queue with the FIFO's accept and error rules.
  task automatic model_step(input bit iw, input bit ir, input logic [WIDTH-1:0] iwd, input bit ifl);
    bit full, empty;
    if (ifl) begin
      model_q.delete();
      model_ov = 0;
      model_un = 0;
      return;
    end
    full  = (model_q.size() == DEPTH);
    empty = (model_q.size() == 0);
    if (iw && full && !ir) model_ov = 1;
    if (ir && empty) model_un = 1;
    if (ir && !empty) void'(model_q.pop_front());
    if (iw && (!full || ir)) model_q.push_back(iwd);
  endtask

  task automatic cycle(input string tag, input bit iw, input bit ir,
                       input logic [WIDTH-1:0] iwd, input bit ifl);
    w = iw; r = ir; wd = iwd; flush = ifl;
    model_step(iw, ir, iwd, ifl);
    @(posedge clk);
    #1;
    w = 0; r = 0; flush = 0;
    check_all(tag);
  endtask

  initial begin
    int written;
    int expect_out;
    int budget;
    bit rw, rr;

    rst_n = 0; flush = 0; w = 0; r = 0; wd = '0;
    model_ov = 0; model_un = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1;
    cycle("idle", 0, 0, 12'h000, 0);

    // Fill to full, then overflow attempt.
    cycle("fill1", 1, 0, 12'h00A, 0);
    cycle("fill2", 1, 0, 12'h00B, 0);
    cycle("fill3", 1, 0, 12'h00C, 0);
    cycle("fill4", 1, 0, 12'h00D, 0);
    cycle("overflow", 1, 0, 12'h00E, 0);
    chk("overflow_set", 32'(overflow), 32'd1);

    // Drain in order, then underflow.
    chk("drain_head", 32'(rd), 32'h00A);
    cycle("drain1", 0, 1, 12'h000, 0);
    cycle("drain2", 0, 1, 12'h000, 0);
    cycle("drain3", 0, 1, 12'h000, 0);
    cycle("drain4", 0, 1, 12'h000, 0);
    cycle("underflow", 0, 1, 12'h000, 0);
    chk("underflow_set", 32'(underflow), 32'd1);

    // Write+read on empty: write taken, underflow raised, no bypass.
    cycle("flush_a", 0, 0, 12'h000, 1);
    cycle("empty_wr", 1, 1, 12'h077, 0);
    chk("empty_wr_rd", 32'(rd), 32'h077);

    // Full pass-through.
    cycle("flush_b", 0, 0, 12'h000, 1);
    for (int i = 1; i <= 4; i++) cycle("pt_fill", 1, 0, 12'(i), 0);
    cycle("passthru", 1, 1, 12'h123, 0);
    chk("pt_count", 32'(count), 32'd4);
    chk("pt_overflow", 32'(overflow), 32'd0);
    cycle("pt_rd1", 0, 1, 12'h000, 0);
    cycle("pt_rd2", 0, 1, 12'h000, 0);
    cycle("pt_rd3", 0, 1, 12'h000, 0);
    chk("pt_tail", 32'(rd), 32'h123);
    cycle("pt_rd4", 0, 1, 12'h000, 0);

    // Wrap-around stream of 37 words with random gating.
    cycle("flush_c", 0, 0, 12'h000, 1);
    written = 0; expect_out = 0; budget = 0;
    while ((expect_out < 37) && (budget < 2000)) begin
      rw = (written < 37) && ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      if (rr && model_q.size() > 0) begin
        chk("stream_order", 32'(rd), 32'(expect_out));
        expect_out++;
      end
      cycle("stream", rw, rr, 12'(written), 0);
      if (rw && (model_q.size() > 0) && (model_q[model_q.size()-1] == 12'(written))) written++;
      chk("stream_cnt_le_depth", 32'(count <= 3'(DEPTH)), 32'd1);
      budget++;
    end
    chk("stream_done", 32'(expect_out), 32'd37);

    // Flush with 3 queued and a write in the same cycle.
    cycle("flush_d", 0, 0, 12'h000, 1);
    cycle("fq1", 1, 0, 12'h101, 0);
    cycle("fq2", 1, 0, 12'h102, 0);
    cycle("fq3", 1, 0, 12'h103, 0);
    cycle("fq_ovr", 0, 1, 12'h000, 0);
    cycle("fq_refill", 1, 0, 12'h104, 0);
    cycle("flush_w", 1, 0, 12'h1FF, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_rempty", 32'(rempty), 32'd1);
    cycle("post_flush_wr", 1, 0, 12'h055, 0);
    chk("post_flush_rd", 32'(rd), 32'h055);

    // Async reset between edges.
    cycle("pre_rst1", 1, 0, 12'h066, 0);
    cycle("pre_rst2", 0, 1, 12'h000, 0);
    cycle("pre_rst3", 0, 1, 12'h000, 0);
    cycle("pre_rst4", 0, 1, 12'h000, 0);
    chk("pre_rst_underflow", 32'(underflow), 32'd1);
    rst_n = 0;
    #2;
    model_q.delete(); model_ov = 0; model_un = 0;
    check_all("async_rst");
    rst_n = 1;
    cycle("after_rst", 1, 0, 12'h0AB, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
